// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and sizes for the matmul accelerator datapath.
//   DATA_WIDTH / BUS_WIDTH : operand and result element widths
//   MAX_DIM                : largest supported matrix dimension
//   DIM_W                  : width of runtime dimension inputs (holds 0..MAX_DIM)
//   IDX_W                  : width of an element index (0..MAX_DIM-1)
//   matA/matB/matc         : operand and result matrices, [row][col]
//   ovf_vec_t              : per-element overflow flags, bit i*MAX_DIM+j
package matmul_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int BUS_WIDTH  = 32;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W      = $clog2(MAX_DIM) + 1;
  localparam int IDX_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matA;
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matB;
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][BUS_WIDTH-1:0]  matc;
  typedef logic [MAX_DIM*MAX_DIM-1:0]                      ovf_vec_t;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} matmul_state_t;

  function automatic logic dimOk(input logic [DIM_W-1:0] d);
    return (d != '0) && (d <= DIM_W'(MAX_DIM));
  endfunction
endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: combinational signed multiply-accumulate.
//   a, b    : signed operands (DATA_WIDTH)
//   acc_in  : running accumulator (BUS_WIDTH)
//   acc_out : acc_in + a*b, wrapping modulo 2^BUS_WIDTH
//   ovf     : signed add overflow, or product did not fit BUS_WIDTH
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int BW = BUS_WIDTH
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [BW-1:0] acc_in,
  output logic [BW-1:0] acc_out,
  output logic          ovf
);
  localparam int PW = 2 * DW;

  logic signed [PW-1:0] prod;
  logic [BW-1:0]        prodExt;
  logic                 truncLoss;

  assign prod = $signed(a) * $signed(b);

  generate
    if (BW >= PW) begin : gExt
      assign prodExt   = BW'(prod);
      assign truncLoss = 1'b0;
    end else begin : gTrunc
      // Truncation loses significance when the kept bits no longer
      // sign-extend back to the full product.
      assign prodExt   = prod[BW-1:0];
      assign truncLoss = (PW'($signed(prodExt)) != prod);
    end
  endgenerate

  assign acc_out = acc_in + prodExt;
  assign ovf     = ((acc_in[BW-1] == prodExt[BW-1]) && (acc_out[BW-1] != acc_in[BW-1]))
                 || truncLoss;
endmodule

// File: rtl/matmul_seq_engine.sv
// matmul_seq_engine: sequential C = A*B (+ C_in) with one shared MAC.
//   clk_i, rst_ni            : clock, async active-low reset
//   start_i, bias_mode_i     : start request (IDLE only), add C_in when set
//   dim_n_i/dim_k_i/dim_m_i  : runtime N, K, M (1..MAX_DIM legal)
//   mat_a_i/mat_b_i/mat_c_i  : operands and bias, latched on accepted start
//   busy_o                   : high in LOAD and CALC
//   done_o                   : single-cycle completion pulse
//   err_o                    : illegal dimension on the last accepted start
//   res_o, ovf_o             : result matrix and per-element sticky overflow
module matmul_seq_engine
  import matmul_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             bias_mode_i,
  input  logic [DIM_W-1:0] dim_n_i,
  input  logic [DIM_W-1:0] dim_k_i,
  input  logic [DIM_W-1:0] dim_m_i,
  input  matA              mat_a_i,
  input  matB              mat_b_i,
  input  matc              mat_c_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output matc              res_o,
  output ovf_vec_t         ovf_o
);
  matmul_state_t state, stateNxt;

  matA              aReg;
  matB              bReg;
  matc              cReg;
  logic             biasReg;
  logic [DIM_W-1:0] nReg, kReg, mReg;
  logic [IDX_W-1:0] iCnt, jCnt, kCnt, iNxt, jNxt;
  logic [BUS_WIDTH-1:0] acc, accNxt, biasNxt;
  logic             ovfRun, macOvf;
  logic             lastK, lastJ, lastI, dimsOk;
  matc              resReg;
  logic [MAX_DIM-1:0][MAX_DIM-1:0] ovfMat;  // flattens to bit i*MAX_DIM+j
  logic             errReg;

  assign dimsOk = dimOk(nReg) && dimOk(kReg) && dimOk(mReg);
  assign lastK  = ({1'b0, kCnt} == kReg - 1'b1);
  assign lastJ  = ({1'b0, jCnt} == mReg - 1'b1);
  assign lastI  = ({1'b0, iCnt} == nReg - 1'b1);

  assign jNxt    = lastJ ? '0 : jCnt + 1'b1;
  assign iNxt    = lastJ ? iCnt + 1'b1 : iCnt;
  // Only consumed when another element follows, so indices are in range.
  assign biasNxt = biasReg ? cReg[iNxt][jNxt] : '0;

  matmul_mac uMac (
    .a      (aReg[iCnt][kCnt]),
    .b      (bReg[kCnt][jCnt]),
    .acc_in (acc),
    .acc_out(accNxt),
    .ovf    (macOvf)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state)
      IDLE: if (start_i) stateNxt = LOAD;
      LOAD: begin
        busy_o   = 1'b1;
        stateNxt = dimsOk ? CALC : DONE;
      end
      CALC: begin
        busy_o = 1'b1;
        if (lastK && lastJ && lastI) stateNxt = DONE;
      end
      DONE: begin
        done_o   = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aReg    <= '0;
      bReg    <= '0;
      cReg    <= '0;
      biasReg <= 1'b0;
      nReg    <= '0;
      kReg    <= '0;
      mReg    <= '0;
      iCnt    <= '0;
      jCnt    <= '0;
      kCnt    <= '0;
      acc     <= '0;
      ovfRun  <= 1'b0;
      resReg  <= '0;
      ovfMat  <= '0;
      errReg  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          aReg    <= mat_a_i;
          bReg    <= mat_b_i;
          cReg    <= mat_c_i;
          biasReg <= bias_mode_i;
          nReg    <= dim_n_i;
          kReg    <= dim_k_i;
          mReg    <= dim_m_i;
          resReg  <= '0;
          ovfMat  <= '0;
          errReg  <= 1'b0;
        end
        LOAD: begin
          if (!dimsOk) errReg <= 1'b1;
          else begin
            iCnt   <= '0;
            jCnt   <= '0;
            kCnt   <= '0;
            acc    <= biasReg ? cReg[0][0] : '0;
            ovfRun <= 1'b0;
          end
        end
        CALC: begin
          if (lastK) begin
            resReg[iCnt][jCnt] <= accNxt;
            ovfMat[iCnt][jCnt] <= ovfRun | macOvf;
            kCnt   <= '0;
            jCnt   <= jNxt;
            iCnt   <= iNxt;
            acc    <= biasNxt;
            ovfRun <= 1'b0;
          end else begin
            kCnt   <= kCnt + 1'b1;
            acc    <= accNxt;
            ovfRun <= ovfRun | macOvf;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_o = resReg;
  assign ovf_o = ovfMat;
  assign err_o = errReg;
endmodule

// File: tb/tb_matmul_seq_engine.sv
// tb_matmul_seq_engine: directed + randomized checks of matmul_seq_engine
// against an arithmetic reference model (exact 64-bit sums, wrapped per step).
module tb_matmul_seq_engine;
  import matmul_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             biasMode = 1'b0;
  logic [DIM_W-1:0] dn = '0, dk = '0, dm = '0;
  matA              ma = '0;
  matB              mb = '0;
  matc              mc = '0;
  logic             busy, done, err;
  matc              res;
  ovf_vec_t         ovf;

  int total = 0;
  int bad   = 0;

  matmul_seq_engine dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .bias_mode_i(biasMode),
    .dim_n_i    (dn),
    .dim_k_i    (dk),
    .dim_m_i    (dm),
    .mat_a_i    (ma),
    .mat_b_i    (mb),
    .mat_c_i    (mc),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .res_o      (res),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrapBus(input longint x);
    logic [BUS_WIDTH-1:0] t;
    t = x[BUS_WIDTH-1:0];
    return longint'($signed(t));
  endfunction

  // Element (i,j) = bias + sum_k A[i][k]*B[k][j], each step wrapped to
  // BUS_WIDTH; overflow when any step's exact value leaves the signed range.
  function automatic void model(input matA a, input matB b, input matc c,
                                input int n, input int k, input int m, input bit bm,
                                output matc r, output ovf_vec_t o);
    longint lo, hi, acc, p, pw, s;
    bit ov;
    r = '0;
    o = '0;
    lo = -(longint'(1) << (BUS_WIDTH - 1));
    hi = (longint'(1) << (BUS_WIDTH - 1)) - 1;
    if (n < 1 || n > MAX_DIM || k < 1 || k > MAX_DIM || m < 1 || m > MAX_DIM) return;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < m; j++) begin
        acc = bm ? longint'($signed(c[i][j])) : 0;
        ov  = 1'b0;
        for (int kk = 0; kk < k; kk++) begin
          p  = longint'($signed(a[i][kk])) * longint'($signed(b[kk][j]));
          pw = wrapBus(p);
          if (pw != p) ov = 1'b1;
          s = acc + pw;
          if (s < lo || s > hi) ov = 1'b1;
          acc = wrapBus(s);
        end
        r[i][j]           = acc[BUS_WIDTH-1:0];
        o[i*MAX_DIM + j]  = ov;
      end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rv();
    case ($urandom_range(0, 3))
      0:       return {1'b1, {(DATA_WIDTH-1){1'b0}}};
      1:       return {1'b0, {(DATA_WIDTH-1){1'b1}}};
      default: return DATA_WIDTH'($urandom);
    endcase
  endfunction

  task automatic randMats();
    for (int i = 0; i < MAX_DIM; i++)
      for (int j = 0; j < MAX_DIM; j++) begin
        ma[i][j] = rv();
        mb[i][j] = rv();
        mc[i][j] = BUS_WIDTH'($urandom);
      end
  endtask

  // Start in the current cycle (cycle 0), scramble inputs afterwards, and
  // check latency, flags and results. Returns in the IDLE cycle after done,
  // so back-to-back calls start one cycle after the previous done.
  task automatic runCase(input int n, input int k, input int m, input bit bm, input string tag);
    matc      expRes;
    ovf_vec_t expOvf;
    bit       legal;
    int       cyc, expLat;
    legal  = n >= 1 && n <= MAX_DIM && k >= 1 && k <= MAX_DIM && m >= 1 && m <= MAX_DIM;
    model(ma, mb, mc, n, k, m, bm, expRes, expOvf);
    expLat = legal ? 2 + n * k * m : 2;
    dn = DIM_W'(n);
    dk = DIM_W'(k);
    dm = DIM_W'(m);
    biasMode = bm;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    randMats();
    biasMode = ~bm;
    check({tag, "_busy_load"}, busy, 1);
    check({tag, "_err_clr"}, err, 0);
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, expLat);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_res"}, res, expRes);
    check({tag, "_ovf"}, ovf, expOvf);
    check({tag, "_err"}, err, !legal);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_res_held"}, res, expRes);
  endtask

  initial begin
    matc      expRes;
    ovf_vec_t expOvf;
    int       cyc, doneCnt, doneCyc;

    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_res", res, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A=[[1,2],[3,4]], B=I
    ma = '0; mb = '0; mc = '0;
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 1; mb[1][1] = 1;
    runCase(2, 2, 2, 1'b0, "ident");
    check("ident_const", res, {32'd4, 32'd3, 32'd2, 32'd1});

    // Wrapping overflow on a 1x2 * 2x1 product
    ma = '0; mb = '0; mc = '0;
    ma[0][0] = 16'h8000; ma[0][1] = 16'h8000;
    mb[0][0] = 16'h8000; mb[1][0] = 16'h8000;
    runCase(1, 2, 1, 1'b0, "wrap");
    check("wrap_const", res, {32'd0, 32'd0, 32'd0, 32'h8000_0000});
    check("wrap_ovf_const", ovf, 4'b0001);

    // Bias mode
    ma = '0; mb = '0;
    ma[0][0] = 2; ma[1][1] = 2;
    mb[0][0] = 3; mb[0][1] = 1; mb[1][0] = 1; mb[1][1] = 3;
    mc[0][0] = 10; mc[0][1] = 32'hFFFF_FFFB; mc[1][0] = 0; mc[1][1] = 7;
    runCase(2, 2, 2, 1'b1, "bias");
    check("bias_const", res, {32'd13, 32'd2, 32'hFFFF_FFFD, 32'd16});

    // Illegal dimension, then a legal start clears err
    randMats();
    runCase(2, 0, 2, 1'b0, "dimk0");
    randMats();
    runCase(2, 1, 2, 1'b1, "after_err");

    for (int t = 0; t < 16; t++) begin
      randMats();
      if (t % 5 == 4)
        runCase($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), "rnd_dim");
      else
        runCase($urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(1, 2),
                1'($urandom), "rnd");
    end

    // Reset mid-CALC with some elements already written
    randMats();
    dn = 2; dk = 2; dm = 2; biasMode = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_res", res, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh run; a start pulse during busy must be ignored
    randMats();
    model(ma, mb, mc, 2, 2, 2, 1'b0, expRes, expOvf);
    dn = 2; dk = 2; dm = 2; biasMode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    doneCnt = 0;
    doneCyc = 0;
    for (cyc = 1; cyc < 30; cyc++) begin
      if (cyc == 4) begin
        dn = 1; dk = 1; dm = 1;
        start = 1'b1;
      end
      if (cyc == 5) start = 1'b0;
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
      end
      @(posedge clk); #1;
    end
    check("busy_start_ignored_cnt", doneCnt, 1);
    check("busy_start_ignored_lat", doneCyc, 10);
    check("busy_start_ignored_res", res, expRes);
    check("busy_start_ignored_ovf", ovf, expOvf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
